// File: rtl/sdm_adc_seq.sv
// sdm_adc_seq: run-time sequencer for the sigma-delta chain with bit-rate strobe, flush/settle control and output FIFO
module sdm_adc_seq #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic [7:0]       settle,
  output logic             sdm_ce,
  output logic             chain_flush,
  input  logic             chain_valid,
  input  logic [15:0]      chain_data,
  output logic             m_valid,
  output logic [15:0]      m_data,
  input  logic             m_ready,
  output logic             busy,
  output logic             overflow,
  input  logic             clr_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FLUSH, SETTLE, RUN} state_t;
  state_t state, state_nx;
  logic [DIV_W-1:0] div_l, cnt, cnt_nx;
  logic [7:0] settle_l, dcnt;
  logic fcnt, active, active_nx, push, pop, full, empty, wr;
  logic [AW:0] wp, rp;
  logic [15:0] mem [FIFO_DEPTH];
  // next state, divider count and FIFO handshake decode
  always_comb begin
    state_nx = !enable ? IDLE :
               state == IDLE ? FLUSH :
               state == FLUSH ? (fcnt ? (settle_l != 8'd0 ? SETTLE : RUN) : FLUSH) :
               (state == SETTLE && chain_valid && dcnt + 8'd1 == settle_l) ? RUN : state;
    active = state == SETTLE || state == RUN;
    active_nx = state_nx == SETTLE || state_nx == RUN;
    cnt_nx = active ? (cnt == div_l ? '0 : cnt + DIV_W'(1)) : '0;
    empty = wp == rp;
    full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    push = state == RUN && enable && chain_valid;
    pop = !empty && m_ready;
    wr = push && (!full || pop);
    m_valid = !empty;
    m_data = empty ? '0 : mem[rp[AW-1:0]];
  end
  // sequencer state, registered outputs and FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      div_l <= '0;
      settle_l <= '0;
      cnt <= '0;
      dcnt <= '0;
      fcnt <= 1'b0;
      sdm_ce <= 1'b0;
      chain_flush <= 1'b0;
      busy <= 1'b0;
      overflow <= 1'b0;
      wp <= '0;
      rp <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && enable) begin
        div_l <= div;
        settle_l <= settle;
      end
      fcnt <= state == FLUSH && state_nx == FLUSH;
      cnt <= active_nx ? cnt_nx : '0;
      dcnt <= state == SETTLE ? dcnt + 8'(chain_valid) : '0;
      sdm_ce <= active_nx && cnt_nx == div_l;
      chain_flush <= state_nx == FLUSH;
      busy <= state_nx != IDLE;
      overflow <= (push && full && !pop) || (overflow && !clr_ovf);
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  // FIFO storage needs no reset; empty pointers mask stale contents
  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= chain_data;
  end
endmodule

// File: tb/tb_sdm_adc_seq.sv
// tb_sdm_adc_seq: scoreboard bench for the sigma-delta run-time sequencer
module tb_sdm_adc_seq;
  logic clk = 0, rst = 1, enable = 0, chain_valid = 0, m_ready = 0, clr_ovf = 0;
  logic [15:0] div = 0, chain_data = 0;
  logic [7:0] settle = 0;
  logic sdm_ce, chain_flush, m_valid, busy, overflow;
  logic [15:0] m_data;
  int checks = 0, errors = 0, pops = 0;
  logic [15:0] q[$];
  bit exp_run = 0, mon_en = 0;

  sdm_adc_seq #(.DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .div(div), .settle(settle),
    .sdm_ce(sdm_ce), .chain_flush(chain_flush), .chain_valid(chain_valid),
    .chain_data(chain_data), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // scoreboard: model FIFO occupancy, compare head on every accepted pop
  always @(negedge clk) begin
    if (mon_en) begin
      bit p;
      p = m_ready && q.size() > 0;
      checks++;
      if (m_valid !== (q.size() > 0)) begin errors++; $display("FAIL m_valid got %b exp %b", m_valid, q.size() > 0); end
      if (p) begin
        checks++;
        pops++;
        if (m_data !== q[0]) begin errors++; $display("FAIL m_data got %h exp %h", m_data, q[0]); end
      end
      if (exp_run && chain_valid && (q.size() < 4 || p)) q.push_back(chain_data);
      if (p) void'(q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    checks += 6;
    if (sdm_ce !== 1'b0) begin errors++; $display("FAIL rst_sdm_ce got %b exp 0", sdm_ce); end
    if (chain_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", chain_flush); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
    if (m_data !== 16'h0) begin errors++; $display("FAIL rst_m_data got %h exp 0", m_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    rst = 0;
    mon_en = 1;
    repeat (2) tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_flush_strobe;
    div = 3;
    settle = 0;
    enable = 1;
    for (int k = 0; k < 14; k++) begin
      tick;
      checks += 3;
      if (chain_flush !== (k < 2)) begin errors++; $display("FAIL flush k=%0d got %b exp %b", k, chain_flush, k < 2); end
      if (sdm_ce !== (k >= 5 && (k - 5) % 4 == 0)) begin errors++; $display("FAIL strobe k=%0d got %b exp %b", k, sdm_ce, (k >= 5 && (k - 5) % 4 == 0)); end
      if (busy !== 1'b1) begin errors++; $display("FAIL run_busy k=%0d got %b exp 1", k, busy); end
    end
  endtask

  task automatic test_settle;
    int p0;
    enable = 0;
    repeat (2) tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %b exp 0", busy); end
    div = 0;
    settle = 6;
    m_ready = 1;
    enable = 1;
    repeat (3) tick;
    p0 = pops;
    for (int i = 1; i <= 8; i++) begin
      exp_run = i > 6;
      chain_valid = 1;
      chain_data = 16'(i);
      tick;
    end
    chain_valid = 0;
    repeat (3) tick;
    checks++;
    if (pops - p0 !== 2) begin errors++; $display("FAIL settle_pops got %0d exp 2", pops - p0); end
  endtask

  task automatic test_overflow;
    m_ready = 0;
    exp_run = 1;
    for (int i = 0; i < 6; i++) begin
      chain_valid = 1;
      chain_data = 16'h10 + 16'(i);
      tick;
      checks++;
      if (overflow !== (i >= 4)) begin errors++; $display("FAIL ovf i=%0d got %b exp %b", i, overflow, i >= 4); end
    end
    chain_valid = 0;
    clr_ovf = 1;
    tick;
    clr_ovf = 0;
    checks += 2;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b exp 0", overflow); end
    if (m_data !== 16'h10) begin errors++; $display("FAIL full_head got %h exp 0010", m_data); end
  endtask

  task automatic test_full_pushpop;
    chain_valid = 1;
    chain_data = 16'h20;
    m_ready = 1;
    tick;
    chain_valid = 0;
    m_ready = 0;
    checks += 2;
    if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_ovf got %b exp 0", overflow); end
    if (m_data !== 16'h11) begin errors++; $display("FAIL pushpop_head got %h exp 0011", m_data); end
  endtask

  task automatic test_disable;
    int p0;
    m_ready = 1;
    tick;
    m_ready = 0;
    p0 = pops;
    checks++;
    if (sdm_ce !== 1'b1) begin errors++; $display("FAIL pre_dis_ce got %b exp 1", sdm_ce); end
    enable = 0;
    exp_run = 0;
    chain_valid = 1;
    chain_data = 16'h99;
    tick;
    checks += 2;
    if (sdm_ce !== 1'b0) begin errors++; $display("FAIL dis_ce got %b exp 0", sdm_ce); end
    if (busy !== 1'b0) begin errors++; $display("FAIL dis_busy got %b exp 0", busy); end
    tick;
    chain_valid = 0;
    m_ready = 1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick;
    tick;
    m_ready = 0;
    checks += 3;
    if (q.size() != 0) begin errors++; $display("FAIL drain_left got %0d exp 0", q.size()); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", m_valid); end
    if (pops - p0 !== 3) begin errors++; $display("FAIL drain_pops got %0d exp 3", pops - p0); end
  endtask

  task automatic test_reset_mid;
    div = 0;
    settle = 0;
    enable = 1;
    repeat (3) tick;
    exp_run = 1;
    chain_valid = 1;
    chain_data = 16'h41;
    tick;
    chain_data = 16'h42;
    tick;
    chain_valid = 0;
    exp_run = 0;
    checks += 2;
    if (sdm_ce !== 1'b1) begin errors++; $display("FAIL pre_rst_ce got %b exp 1", sdm_ce); end
    if (m_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got %b exp 1", m_valid); end
    mon_en = 0;
    #2 rst = 1;
    #1;
    checks += 4;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", m_valid); end
    if (sdm_ce !== 1'b0) begin errors++; $display("FAIL async_ce got %b exp 0", sdm_ce); end
    if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b exp 0", busy); end
    if (m_data !== 16'h0) begin errors++; $display("FAIL async_data got %h exp 0", m_data); end
    q.delete();
    tick;
    rst = 0;
    mon_en = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks += 2;
      if (chain_flush !== (k < 2)) begin errors++; $display("FAIL reflush k=%0d got %b exp %b", k, chain_flush, k < 2); end
      if (busy !== 1'b1) begin errors++; $display("FAIL rebusy k=%0d got %b exp 1", k, busy); end
    end
  endtask

  initial begin
    test_reset;
    test_flush_strobe;
    test_settle;
    test_overflow;
    test_full_pushpop;
    test_disable;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
